// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory load/store unit: RV32I width codes,
// response error codes, FSM state encoding and the request classifier.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Checks are ordered so an illegal code wins over misalignment, which wins over range.
    function automatic logic [1:0] classify(input logic       write,
                                            input logic [2:0] funct3,
                                            input logic [1:0] off,
                                            input logic       out_of_range);
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111 || (write && funct3[2]))
            return ERR_ILLEGAL;
        if ((funct3[1:0] == 2'b01 && off[0]) || (funct3[1:0] == 2'b10 && off != 2'b00))
            return ERR_MISALIGN;
        if (out_of_range)
            return ERR_RANGE;
        return ERR_OK;
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request, response and dmem word-port signals of the load/store unit.
interface dmem_lsu_if #(parameter int MEM_AW = 10);

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic [1:0]        resp_err;
    logic [3:0]        mem_writeb;
    logic              mem_read;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_writeb, mem_read, mem_addr, mem_wdata
    );

    modport slave (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_writeb, mem_read, mem_addr, mem_wdata
    );

endinterface

// File: rtl/dmem_lsu_lane.sv
// Byte-lane steering: store data replication and write enables, plus load
// extraction and sign/zero extension from a returned word.
module lsu_lane
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] sdata,
    input  logic [31:0] rword,
    output logic [3:0]  writeb,
    output logic [31:0] wdata,
    output logic [31:0] ldata
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        writeb = 4'b1111;
        wdata  = sdata;
        case (funct3[1:0])
            2'b00: begin
                writeb = 4'b0001 << off;
                wdata  = {4{sdata[7:0]}};
            end
            2'b01: begin
                writeb = off[1] ? 4'b1100 : 4'b0011;
                wdata  = {2{sdata[15:0]}};
            end
            default: begin
                writeb = 4'b1111;
                wdata  = sdata;
            end
        endcase
    end

    always_comb begin
        sel_byte = rword[7:0];
        case (off)
            2'd0:    sel_byte = rword[7:0];
            2'd1:    sel_byte = rword[15:8];
            2'd2:    sel_byte = rword[23:16];
            default: sel_byte = rword[31:24];
        endcase
        sel_half = off[1] ? rword[31:16] : rword[15:0];
    end

    always_comb begin
        ldata = 32'h0;
        case (funct3)
            F3_B:    ldata = {{24{sel_byte[7]}}, sel_byte};
            F3_BU:   ldata = {24'h0, sel_byte};
            F3_H:    ldata = {{16{sel_half[15]}}, sel_half};
            F3_HU:   ldata = {16'h0, sel_half};
            F3_W:    ldata = rword;
            default: ldata = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// RV32I load/store unit driving a registered-read dmem word port; one
// transaction at a time, faults reported without touching memory.
module dmem_lsu #(
    parameter int          MEM_AW = 10,
    parameter logic [31:0] BASE   = 32'h0000_0000
) (
    input  logic      clk,
    input  logic      rst_n,
    dmem_lsu_if.master bus
);
    import dmem_pkg::*;

    logic [1:0]        state;
    logic              lat_write;
    logic [2:0]        lat_f3;
    logic [1:0]        lat_off;
    logic              resp_valid_q;
    logic [31:0]       resp_rdata_q;
    logic [1:0]        resp_err_q;
    logic [3:0]        mem_writeb_q;
    logic              mem_read_q;
    logic [MEM_AW-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;

    logic [31:0] off_addr;
    logic        out_of_range;
    logic [1:0]  req_err;
    logic [2:0]  lane_f3;
    logic [1:0]  lane_off;
    logic [3:0]  lane_writeb;
    logic [31:0] lane_wdata;
    logic [31:0] lane_ldata;

    assign off_addr     = bus.req_addr - BASE;
    assign out_of_range = (off_addr >> (MEM_AW + 2)) != 32'h0;
    assign req_err      = classify(bus.req_write, bus.req_funct3, bus.req_addr[1:0], out_of_range);

    // The lane steers live request fields at accept time and latched ones afterwards.
    assign lane_f3  = (state == ST_IDLE) ? bus.req_funct3    : lat_f3;
    assign lane_off = (state == ST_IDLE) ? bus.req_addr[1:0] : lat_off;

    lsu_lane u_lane (
        .funct3 (lane_f3),
        .off    (lane_off),
        .sdata  (bus.req_wdata),
        .rword  (bus.mem_rdata),
        .writeb (lane_writeb),
        .wdata  (lane_wdata),
        .ldata  (lane_ldata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            lat_write    <= 1'b0;
            lat_f3       <= 3'b000;
            lat_off      <= 2'b00;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= ERR_OK;
            mem_writeb_q <= 4'b0000;
            mem_read_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        lat_write    <= bus.req_write;
                        lat_f3       <= bus.req_funct3;
                        lat_off      <= bus.req_addr[1:0];
                        resp_rdata_q <= 32'h0;
                        resp_err_q   <= req_err;
                        if (req_err != ERR_OK) begin
                            resp_valid_q <= 1'b1;
                            state        <= ST_RESP;
                        end else begin
                            mem_addr_q <= off_addr[MEM_AW+1:2];
                            if (bus.req_write) begin
                                mem_writeb_q <= lane_writeb;
                                mem_wdata_q  <= lane_wdata;
                            end else begin
                                mem_read_q <= 1'b1;
                            end
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    mem_read_q   <= 1'b0;
                    mem_writeb_q <= 4'b0000;
                    if (lat_write) begin
                        resp_valid_q <= 1'b1;
                        state        <= ST_RESP;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    resp_rdata_q <= lane_ldata;
                    resp_valid_q <= 1'b1;
                    state        <= ST_RESP;
                end
                default: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.mem_writeb = mem_writeb_q;
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Initiator side of the data-memory port: the CPU's load/store unit.
- Accepts one RV32I load/store request at a time from the execute stage.
- Drives the dmem word port: byte write enables, read strobe, 10-bit word address, write data. Registered read data returns one cycle after the strobe.
- Returns a sign/zero-extended load result, or a store completion, to writeback via a valid/ready response; misaligned, out-of-range and illegal accesses are flagged without touching memory.

Parameters:
- MEM_AW, 10: dmem word-address width; region size is 4*2^MEM_AW bytes.
- BASE, 32'h0000_0000: byte base address of the dmem region; must be region-size aligned.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  LSU can accept (high only in IDLE)
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width/sign code
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  2  00 ok, 01 misaligned, 10 out of range, 11 illegal funct3
- mem_writeb  out  4  per-byte write enables
- mem_read  out  1  read strobe
- mem_addr  out  MEM_AW  word address
- mem_wdata  out  32  lane-aligned write data
- mem_rdata  in  32  registered read data, valid the cycle after the mem_read edge

Behaviour:
- Reset (async, rst_n low): state IDLE. req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_writeb=0, mem_read=0, mem_addr=0, mem_wdata=0.
  - Mid-transaction reset aborts immediately.
  - All mem_* outputs are registers, so the strobes drop asynchronously.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: on req_valid & req_ready, latch the request and classify it. Error priority is illegal, then misaligned, then range.
  - Illegal: funct3 in {011,110,111}, or a store with funct3 100/101.
  - Misaligned: half-word access with addr[0]=1; word access with addr[1:0]!=0.
  - Out of range: (addr - BASE) >= 4*2^MEM_AW.
  - Error: go to RESP with resp_err set and no memory access.
  - OK: load mem_addr=(addr-BASE)[MEM_AW+1:2] and set mem_read or mem_writeb/mem_wdata for ISSUE; go to ISSUE.
- Store lane alignment:
  - SB: wdata = 4 copies of byte, writeb = 1 << addr[1:0].
  - SH: wdata = 2 copies of half, writeb = addr[1] ? 1100 : 0011.
  - SW: wdata unchanged, writeb = 1111.
- ISSUE: mem strobes are high for exactly this one cycle.
  - Store: next state RESP.
  - Load: next state WAIT.
  - Strobes clear on exit.
- WAIT: sample mem_rdata and extract by offset addr[1:0].
  - LB/LBU: byte at bits [8*off+7 : 8*off], sign-/zero-extended.
  - LH/LHU: half at bits [16*addr[1]+15 : 16*addr[1]], extended.
  - LW: whole word.
  - Register the result into resp_rdata; go to RESP.
- RESP: resp_valid=1; hold resp_rdata/resp_err stable until resp_ready. On resp_valid & resp_ready, go to IDLE and clear resp_valid.
- req_ready=0 outside IDLE, so there is no back-to-back overlap. Throughput is one transaction per 3 cycles for stores and 4 for loads, with resp_ready tied high.
- Latency from the accept edge to resp_valid high: error 1 cycle, store 2, load 3.
- mem_read and mem_writeb are never both nonzero. The mem_* outputs never change while no transaction is in ISSUE.
- req_* inputs are ignored outside IDLE; only latched copies are used after accept.

Decomposition:
- Package dmem_pkg:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - Error codes ERR_OK/ERR_MISALIGN/ERR_RANGE/ERR_ILLEGAL.
  - FSM state encoding.
- Sub-module lsu_lane (combinational, ~60 lines):
  - Inputs: funct3, addr[1:0], store data, read word.
  - Outputs: writeb, aligned wdata, extended load data.
  - Used for both directions so the bench can check it standalone.

Test Plan:
- SW 0x1000_0004?no: with BASE=0, SW addr 0x0000_0010 data 0xDEADBEEF: mem_writeb=1111, mem_addr=4, mem_wdata=0xDEADBEEF for exactly one cycle; resp_valid 2 cycles after accept, resp_err=00, resp_rdata=0.
- After the word at index 4 is 0x8421F00D:
  - LB 0x13 -> resp_rdata=0xFFFFFF84.
  - LBU 0x13 -> 0x00000084.
  - LH 0x12 -> 0xFFFF8421.
  - LHU 0x10 -> 0x0000F00D.
  - Each response arrives 3 cycles after accept.
- SB 0x11 data 0x000000AA -> mem_writeb=0010, mem_wdata=0xAAAAAAAA. SH 0x12 data 0x1234 -> mem_writeb=1100, mem_wdata=0x12341234.
- Errors, each with no mem_read/mem_writeb pulse and resp_valid 1 cycle after accept:
  - LW 0x0000_0006 -> resp_err=01.
  - LW 0x0000_1000 -> resp_err=10.
  - Store with funct3=100 -> resp_err=11.
  - funct3=011 at a misaligned address -> resp_err=11.
- Backpressure: resp_ready low for 5 cycles -> resp_valid, resp_rdata and resp_err stay stable and req_ready stays 0. Request held on req_valid meanwhile -> accepted only in the cycle after the response handshake.
- Reset mid-transaction: assert rst_n=0 during ISSUE of an SW -> mem_writeb is 0 immediately (before the next edge), state is IDLE, req_ready=1, resp_valid=0 after release.
